// File: rtl/pm_min_select.sv
// pm_min_select: pipelined minimum-path-metric selector.
// A registered binary compare tree picks, per beat, the (metric, data) pair
// with the smallest unsigned metric. Ties go to the lower channel index.
// Handshake: a beat moves on in_valid && in_ready, and a result moves on
// out_valid && out_ready. in_ready = !out_valid || out_ready, so the whole
// tree advances together or holds together. A source seeing in_ready low must
// keep its beat presented.
module pm_min_select #(
  parameter int NUM_CH  = 4,
  parameter int PM_W    = 7,
  parameter int DATA_W  = 8,
  parameter int NORM_TH = 2**(PM_W-1),
  localparam int LVL    = $clog2(NUM_CH),
  localparam int IW     = (LVL > 1) ? LVL : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*PM_W-1:0]   pm_in,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        data_out,
  output logic [IW-1:0]            min_idx,
  output logic [PM_W-1:0]          min_pm,
  output logic                     norm_req
);

  // Registered tree stages 1..LVL. Entry j of stage s is the winner of
  // entries 2j and 2j+1 of stage s-1. Entries past NUM_CH>>s stay at zero.
  logic              st_v_q    [1:LVL][0:NUM_CH-1];
  logic              st_v_d    [1:LVL][0:NUM_CH-1];
  logic [PM_W-1:0]   st_pm_q   [1:LVL][0:NUM_CH-1];
  logic [PM_W-1:0]   st_pm_d   [1:LVL][0:NUM_CH-1];
  logic [DATA_W-1:0] st_data_q [1:LVL][0:NUM_CH-1];
  logic [DATA_W-1:0] st_data_d [1:LVL][0:NUM_CH-1];
  logic [IW-1:0]     st_idx_q  [1:LVL][0:NUM_CH-1];
  logic [IW-1:0]     st_idx_d  [1:LVL][0:NUM_CH-1];
  logic              norm_q;
  logic              norm_d;

  // Uniform view of every level. Level 0 is the unregistered input beat.
  logic              tv_v    [0:LVL][0:NUM_CH-1];
  logic [PM_W-1:0]   tv_pm   [0:LVL][0:NUM_CH-1];
  logic [DATA_W-1:0] tv_data [0:LVL][0:NUM_CH-1];
  logic [IW-1:0]     tv_idx  [0:LVL][0:NUM_CH-1];

  logic adv;

  // Whole-pipeline advance: move unless a result is stuck at the output.
  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
  end

  // Build the per-level view from the input beat and the stage registers.
  always_comb begin
    for (int j = 0; j < NUM_CH; j++) begin
      tv_v[0][j]    = in_valid;
      tv_pm[0][j]   = pm_in[j*PM_W +: PM_W];
      tv_data[0][j] = data_in[j*DATA_W +: DATA_W];
      tv_idx[0][j]  = IW'(j);
    end
    for (int s = 1; s <= LVL; s++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        tv_v[s][j]    = st_v_q[s][j];
        tv_pm[s][j]   = st_pm_q[s][j];
        tv_data[s][j] = st_data_q[s][j];
        tv_idx[s][j]  = st_idx_q[s][j];
      end
    end
  end

  // Pairwise compare for every stage. Payload only updates for a valid
  // winner, so bubbles leave the last result on the outputs.
  always_comb begin
    int w;
    w = 0;
    for (int s = 1; s <= LVL; s++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        st_v_d[s][j]    = st_v_q[s][j];
        st_pm_d[s][j]   = st_pm_q[s][j];
        st_data_d[s][j] = st_data_q[s][j];
        st_idx_d[s][j]  = st_idx_q[s][j];
      end
    end
    norm_d = norm_q;
    if (adv) begin
      for (int s = 1; s <= LVL; s++) begin
        for (int j = 0; j < (NUM_CH >> s); j++) begin
          // Right entry wins only when strictly smaller: lowest index on ties.
          w = (tv_pm[s-1][2*j+1] < tv_pm[s-1][2*j]) ? (2*j + 1) : (2*j);
          st_v_d[s][j] = tv_v[s-1][w];
          if (tv_v[s-1][w]) begin
            st_pm_d[s][j]   = tv_pm[s-1][w];
            st_data_d[s][j] = tv_data[s-1][w];
            st_idx_d[s][j]  = tv_idx[s-1][w];
          end
        end
      end
      if (st_v_d[LVL][0]) begin
        norm_d = (int'(st_pm_d[LVL][0]) >= NORM_TH);
      end
    end
  end

  // Stage registers with synchronous active-low reset dominating everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 1; s <= LVL; s++) begin
        for (int j = 0; j < NUM_CH; j++) begin
          st_v_q[s][j]    <= 1'b0;
          st_pm_q[s][j]   <= '0;
          st_data_q[s][j] <= '0;
          st_idx_q[s][j]  <= '0;
        end
      end
      norm_q <= 1'b0;
    end else begin
      for (int s = 1; s <= LVL; s++) begin
        for (int j = 0; j < NUM_CH; j++) begin
          st_v_q[s][j]    <= st_v_d[s][j];
          st_pm_q[s][j]   <= st_pm_d[s][j];
          st_data_q[s][j] <= st_data_d[s][j];
          st_idx_q[s][j]  <= st_idx_d[s][j];
        end
      end
      norm_q <= norm_d;
    end
  end

  // Final stage drives the outputs directly.
  always_comb begin
    out_valid = st_v_q[LVL][0];
    data_out  = st_data_q[LVL][0];
    min_idx   = st_idx_q[LVL][0];
    min_pm    = st_pm_q[LVL][0];
    norm_req  = norm_q & st_v_q[LVL][0];
  end

endmodule

// File: tb/tb_pm_min_select.sv
// Bench for pm_min_select: directed beats, queue scoreboard, 8-channel build.
`timescale 1ns/1ps
module tb_pm_min_select;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, norm_req;
  logic [27:0] pm_in;
  logic [31:0] data_in;
  logic [7:0]  data_out;
  logic [1:0]  min_idx;
  logic [6:0]  min_pm;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, norm_req8;
  logic [55:0] pm_in8;
  logic [63:0] data_in8;
  logic [7:0]  data_out8;
  logic [2:0]  min_idx8;
  logic [6:0]  min_pm8;

  logic [17:0] exp_q[$];
  int          pop_cyc_q[$];
  int          cyc = 0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;

  // Hand-computed table: metrics ch0..ch3, expected index/metric/norm.
  int tbl_pm   [8][4] = '{'{20,30,40,50}, '{30,20,40,50}, '{30,40,20,50},
                          '{30,40,50,20}, '{70,66,90,65}, '{1,0,0,1},
                          '{127,126,127,126}, '{64,63,64,63}};
  int tbl_idx  [8] = '{0, 1, 2, 3, 3, 1, 1, 1};
  int tbl_epm  [8] = '{20, 20, 20, 20, 65, 0, 126, 63};
  int tbl_norm [8] = '{0, 0, 0, 0, 1, 0, 1, 0};

  pm_min_select #(.NUM_CH(4), .PM_W(7), .DATA_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pm_in(pm_in), .data_in(data_in), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .min_idx(min_idx),
    .min_pm(min_pm), .norm_req(norm_req)
  );

  pm_min_select #(.NUM_CH(8), .PM_W(7), .DATA_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .pm_in(pm_in8), .data_in(data_in8), .out_valid(out_valid8),
    .out_ready(out_ready8), .data_out(data_out8), .min_idx(min_idx8),
    .min_pm(min_pm8), .norm_req(norm_req8)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [27:0] pk(input int a, input int b, input int c, input int d);
    return {7'(d), 7'(c), 7'(b), 7'(a)};
  endfunction

  // Present a beat until accepted; optionally push its expected result.
  task automatic send(input logic [27:0] pm, input logic [31:0] data, input int eidx,
                      input int epm, input int enorm, input bit push);
    bit acc;
    logic [7:0] ed;
    in_valid = 1'b1;
    pm_in    = pm;
    data_in  = data;
    acc      = 1'b0;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) check("send_accept", 32'(acc), 32'd1);
    else if (push) begin
      ed = data[eidx*8 +: 8];
      exp_q.push_back({ed, 2'(eidx), 7'(epm), 1'(enorm)});
    end
  endtask

  task automatic send_tbl(input int i);
    logic [31:0] d;
    for (int k = 0; k < 4; k++) d[k*8 +: 8] = 8'(i*16 + k);
    send(pk(tbl_pm[i][0], tbl_pm[i][1], tbl_pm[i][2], tbl_pm[i][3]), d,
         tbl_idx[i], tbl_epm[i], tbl_norm[i], 1'b1);
  endtask

  // Monitor: pop and compare on every consumed result.
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("sb_result", {14'd0, data_out, min_idx, min_pm, norm_req}, {14'd0, e});
      end
      pop_cyc_q.push_back(cyc);
    end
  end

  initial begin
    logic [20:0] cap;
    int n, ghost;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; pm_in = '0; data_in = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; pm_in8 = '0; data_in8 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_min_idx", 32'(min_idx), 32'd0);
    check("rst_min_pm", 32'(min_pm), 32'd0);
    check("rst_norm_req", 32'(norm_req), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    // out_ready low with out_valid low must not stall
    out_ready = 1'b0;
    @(negedge clk);
    check("idle_no_stall", 32'(in_ready), 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;

    // Basic beat and latency
    send(pk(10, 5, 7, 9), 32'hA3A2A1A0, 1, 5, 0, 1'b1);
    @(negedge clk); check("lat_early", 32'(out_valid), 32'd0);
    @(negedge clk); check("lat_on_time", 32'(out_valid), 32'd1);
    repeat (3) @(posedge clk); #1;

    // Ties and norm threshold
    send(pk(3, 3, 3, 3), 32'hB3B2B1B0, 0, 3, 0, 1'b1);
    send(pk(9, 4, 4, 8), 32'hC3C2C1C0, 1, 4, 0, 1'b1);
    send(pk(9, 4, 4, 2), 32'hD3D2D1D0, 3, 2, 0, 1'b1);
    send(pk(127, 127, 127, 127), 32'hE3E2E1E0, 0, 127, 1, 1'b1);
    send(pk(63, 100, 70, 80), 32'h13121110, 0, 63, 0, 1'b1);
    send(pk(100, 64, 90, 127), 32'h23222120, 1, 64, 1, 1'b1);
    repeat (4) @(posedge clk); #1;

    // Burst of 8 with out_ready high: consecutive results
    for (int i = 0; i < 8; i++) send_tbl(i);
    repeat (4) @(posedge clk); #1;
    n = pop_cyc_q.size();
    for (int i = 1; i < 8; i++)
      check("burst_gap", 32'(pop_cyc_q[n-8+i] - pop_cyc_q[n-9+i]), 32'd1);

    // Stall mid-stream for 3 cycles
    fork
      begin
        for (int i = 0; i < 8; i++) send_tbl(i);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        cap = {out_valid, data_out, min_idx, min_pm, norm_req, 2'b00};
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        repeat (2) begin
          @(negedge clk);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          check("stall_hold", 32'({out_valid, data_out, min_idx, min_pm, norm_req, 2'b00}), 32'(cap));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk); #1;

    // in_valid 1,0,1 -> out_valid 1,0,1
    send_tbl(0);
    @(posedge clk); #1;
    send_tbl(1);
    @(negedge clk); check("tog_gap", 32'(out_valid), 32'd0);
    @(negedge clk); check("tog_second", 32'(out_valid), 32'd1);
    repeat (3) @(posedge clk); #1;

    // Reset with two beats in flight: they must vanish
    out_ready = 1'b0;
    send(pk(1, 2, 3, 4), 32'h77665544, 0, 1, 0, 1'b0);
    send(pk(4, 3, 2, 1), 32'h88776655, 3, 1, 0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst2_out_valid", 32'(out_valid), 32'd0);
    check("rst2_data_out", 32'(data_out), 32'd0);
    check("rst2_min_idx", 32'(min_idx), 32'd0);
    check("rst2_min_pm", 32'(min_pm), 32'd0);
    check("rst2_norm_req", 32'(norm_req), 32'd0);
    out_ready = 1'b1;
    ghost = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) ghost++;
    end
    check("rst2_no_ghost", 32'(ghost), 32'd0);

    // 8-channel build: ch6 metric 0, others 50, 3-cycle latency
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      pm_in8[k*7 +: 7]   = (k == 6) ? 7'd0 : 7'd50;
      data_in8[k*8 +: 8] = 8'(8'hC0 + k);
    end
    in_valid8 = 1'b1;
    @(posedge clk); #1 in_valid8 = 1'b0;
    @(negedge clk); check("ch8_lat1", 32'(out_valid8), 32'd0);
    @(negedge clk); check("ch8_lat2", 32'(out_valid8), 32'd0);
    @(negedge clk); check("ch8_valid", 32'(out_valid8), 32'd1);
    check("ch8_idx", 32'(min_idx8), 32'd6);
    check("ch8_pm", 32'(min_pm8), 32'd0);
    check("ch8_data", 32'(data_out8), 32'hC6);
    check("ch8_norm", 32'(norm_req8), 32'd0);

    // Final report
    repeat (3) @(posedge clk);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
